note_sequencer: RTL and testbench
=================================

# note_sequencer

Sound-event sequencer that sits directly upstream of the piezo tone generator. It accepts one-cycle event requests from the vending-machine controller (coin inserted, product dispensed) and turns each into a four-note playback sequence. It drives the generator's `note_state` code and a `note_played` step index (1..4), holding each step for a fixed number of clock cycles. One further request may be buffered while a sequence is playing.

## Interface
- `NOTE_CYCLES`, default 250000: clock cycles per note step (0.25 s at 1 MHz); legal range ≥ 2.
- `CNT_W`, default 20: duration counter width; must satisfy 2^CNT_W ≥ `NOTE_CYCLES`.

- `clk` in 1: system clock (1 MHz in the product build).
- `rst` in 1: one clock; reset is synchronous and active-high.
- `note_req` in 6: one-hot-per-event request pulses.
  - bit0 100-won coin, bit1 500-won, bit2 1000-won.
  - bit3 product 1, bit4 product 2, bit5 product 3.
- `note_state` out 4: event code to tone generator; 0 = silent, 1..6 = event bit index + 1.
- `note_played` out 3: current step; 0 = silent, 1..4 = note step.
- `busy` out 1: high while a sequence is playing.
- `seq_done` out 1: one-cycle pulse when a sequence's 4th step completes.

## Operation
- Event encoding: when several `note_req` bits are high in one cycle, the highest set bit wins. Products therefore take priority over coins. Code = index + 1.
- State machine: IDLE and PLAY. All outputs registered.
- IDLE:
  - `note_req` == 0: stay in IDLE, outputs 0.
  - Otherwise: load `note_state` = encoded code, `note_played` = 1, duration counter = 0, go to PLAY.
- PLAY:
  - Counter increments each cycle.
  - When the counter reaches `NOTE_CYCLES`-1, the counter resets to 0 and the step advances:
    - `note_played` 1→2→3→4.
    - On the last cycle of step 4, the sequence ends.
- Pending slot (one entry: valid flag + 4-bit code):
  - Any nonzero `note_req` in PLAY writes the slot.
  - The newest request overwrites an older pending one; no counting, no FIFO.
- Sequence end, evaluated with pending_next = (`note_req` ≠ 0 ? this cycle's code : slot):
  - pending_next valid: load that code, `note_played` = 1, counter = 0, clear slot, stay in PLAY with no silent gap.
  - Otherwise: `note_state` = 0, `note_played` = 0, go to IDLE.
  - Either case: `seq_done` = 1 for exactly one cycle.
- Requests never restart or shorten the sequence currently playing.
- `note_state` is constant for all four steps of a sequence.

## Timing
- Reset values: `note_state`=0, `note_played`=0, `busy`=0, `seq_done`=0. Counter, state and pending slot are cleared.
- `rst` has priority over everything. Reset mid-sequence:
  - Outputs are 0 on the cycle after the `rst` edge.
  - The pending request is discarded.
  - Requests present while `rst` is high are ignored.
- Latency: a request sampled at edge E0 in IDLE gives `note_played`=1, `busy`=1 from E0.
- Step changes occur at E0+k·`NOTE_CYCLES` for k = 1..3.
- Sequence end at E0+4·`NOTE_CYCLES`: each step lasts exactly `NOTE_CYCLES` cycles.
- `busy` = (state == PLAY). It stays high across back-to-back sequences.
- `seq_done` is registered and asserted on the cycle following the end edge, together with the new `note_played` value (0 or 1).
- Counter arithmetic is unsigned `CNT_W` bits. The compare is equality with `NOTE_CYCLES`-1, so the counter never wraps.

## Test plan
Bench uses `NOTE_CYCLES`=4.
1. Reset: hold `rst` 3 cycles with `note_req`=6'h3F -> all outputs 0 throughout and 1 cycle after release; no sequence starts.
2. Single coin: `note_req`=6'b000001 for one cycle at E0 -> `note_state`=1 from E0; `note_played`=1,2,3,4 at E0, E0+4, E0+8, E0+12; at E0+16 both outputs 0, `busy`=0, `seq_done`=1 for one cycle.
3. Simultaneous requests: `note_req`=6'b001101 in IDLE -> `note_state`=4 (product 1 wins).
4. Back-to-back: start 500-won (code 2); pulse bit4 during step 2 -> at end edge `note_state`=5, `note_played`=1, `busy` stays 1, `seq_done` pulses; code 5 plays 16 cycles, then IDLE.
5. Overwrite: during code-1 playback pulse bit0 at step 1, then bit3 at step 3 -> only code 4 plays afterwards, then IDLE. A request on the exact end cycle, with the slot holding code 4, starts the new code instead.
6. Reset mid-play: assert `rst` during step 3 with the slot holding code 6 -> next cycle all outputs 0; after release stays IDLE with no playback.

Source files
------------

// File: rtl/note_sequencer.sv
// Four-step sound-event sequencer feeding the piezo tone generator.
// Turns one-cycle event requests into timed note steps and buffers one pending request.
module note_sequencer #(
    parameter int NOTE_CYCLES = 250000,
    parameter int CNT_W       = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] note_req,
    output logic [3:0] note_state,
    output logic [2:0] note_played,
    output logic       busy,
    output logic       seq_done
);
    typedef enum logic {IDLE, PLAY} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NOTE_CYCLES - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       code_n;
    logic [2:0]       played_n;
    logic [3:0]       pend_code, pend_code_n;
    logic             pend_valid, pend_valid_n;
    logic             done_n;
    logic [3:0]       req_code;
    logic             req_any;

    // Highest set request bit wins, so products outrank coins.
    always_comb begin
        req_code = 4'd0;
        for (int i = 0; i < 6; i++) begin
            if (note_req[i]) req_code = 4'(i + 1);
        end
    end

    assign req_any = |note_req;
    assign busy    = (state == PLAY);

    always_comb begin
        // NOTE: every next value takes a default first so no branch can infer a latch.
        state_n      = state;
        cnt_n        = cnt;
        code_n       = note_state;
        played_n     = note_played;
        pend_valid_n = pend_valid;
        pend_code_n  = pend_code;
        done_n       = 1'b0;

        case (state)
            IDLE: begin
                if (req_any) begin
                    state_n  = PLAY;
                    code_n   = req_code;
                    played_n = 3'd1;
                    cnt_n    = '0;
                end
            end
            PLAY: begin
                if (req_any) begin
                    pend_valid_n = 1'b1;
                    pend_code_n  = req_code;
                end
                if (cnt == LAST_CNT) begin
                    cnt_n = '0;
                    if (note_played == 3'd4) begin
                        // A request on the end cycle beats the buffered one.
                        done_n       = 1'b1;
                        pend_valid_n = 1'b0;
                        if (req_any) begin
                            code_n   = req_code;
                            played_n = 3'd1;
                        end else if (pend_valid) begin
                            code_n   = pend_code;
                            played_n = 3'd1;
                        end else begin
                            state_n  = IDLE;
                            code_n   = 4'd0;
                            played_n = 3'd0;
                        end
                    end else begin
                        played_n = note_played + 3'd1;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            note_state  <= 4'd0;
            note_played <= 3'd0;
            pend_valid  <= 1'b0;
            pend_code   <= 4'd0;
            seq_done    <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            note_state  <= code_n;
            note_played <= played_n;
            pend_valid  <= pend_valid_n;
            pend_code   <= pend_code_n;
            seq_done    <= done_n;
        end
    end
endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: a sequence-level model predicts which codes start
// on which edge; an independent monitor checks every cycle of each observed sequence.
module tb_note_sequencer;
    localparam int N = 4;

    typedef struct {
        int code;
        int start;
    } seq_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] note_req = 6'd0;
    logic [3:0] note_state;
    logic [2:0] note_played;
    logic       busy;
    logic       seq_done;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   edge_n   = 0;
    logic rst_seen = 1'b1;
    seq_t exp_q[$];

    // Reference model state: sequences as (code, start edge) plus a one-entry slot.
    bit   m_busy = 0;
    int   m_start = 0;
    bit   m_pend_valid = 0;
    int   m_pend_code = 0;

    note_sequencer #(.NOTE_CYCLES(N), .CNT_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .note_req   (note_req),
        .note_state (note_state),
        .note_played(note_played),
        .busy       (busy),
        .seq_done   (seq_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        edge_n   <= edge_n + 1;
        rst_seen <= rst;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_n, act, exp);
        end
    endtask

    function automatic int encode(input logic [5:0] req);
        for (int i = 5; i >= 0; i--) begin
            if (req[i]) return i + 1;
        end
        return 0;
    endfunction

    // Predict the effect of the inputs sampled at edge e.
    task automatic model(input int e, input logic r, input logic [5:0] req);
        int pn;
        if (r) begin
            m_busy       = 0;
            m_pend_valid = 0;
        end else if (!m_busy) begin
            if (req != 0) begin
                m_busy  = 1;
                m_start = e;
                exp_q.push_back('{code: encode(req), start: e});
            end
        end else if (e == m_start + 4 * N) begin
            pn = (req != 0) ? encode(req) : (m_pend_valid ? m_pend_code : 0);
            m_pend_valid = 0;
            if (pn != 0) begin
                m_start = e;
                exp_q.push_back('{code: pn, start: e});
            end else begin
                m_busy = 0;
            end
        end else if (req != 0) begin
            m_pend_valid = 1;
            m_pend_code  = encode(req);
        end
    endtask

    task automatic step(input logic r, input logic [5:0] req);
        @(negedge clk);
        rst      = r;
        note_req = req;
        model(edge_n + 1, r, req);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 6'd0);
    endtask

    // Monitor: detect sequence starts, pop the expectation, then check each cycle.
    initial begin
        bit   trk = 0;
        int   t_code = 0;
        int   t_start = 0;
        int   prev_played = 0;
        bit   exp_done;
        seq_t s;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (rst_seen) begin
                check("reset_state", note_state, 0);
                check("reset_played", note_played, 0);
                check("reset_busy", busy, 0);
                check("reset_done", seq_done, 0);
                trk = 0;
            end else begin
                exp_done = trk && (edge_n == t_start + 4 * N);
                if (exp_done) trk = 0;
                check("seq_done", seq_done, exp_done);
                if (note_played == 3'd1 && prev_played != 1) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_start", 1, 0);
                    end else begin
                        s = exp_q.pop_front();
                        check("start_code", note_state, s.code);
                        check("start_edge", edge_n, s.start);
                        trk     = 1;
                        t_code  = s.code;
                        t_start = s.start;
                    end
                end
                if (trk) begin
                    check("step", note_played, 1 + (edge_n - t_start) / N);
                    check("code_hold", note_state, t_code);
                    check("busy_play", busy, 1);
                end else begin
                    check("idle_state", note_state, 0);
                    check("idle_played", note_played, 0);
                    check("idle_busy", busy, 0);
                end
            end
            prev_played = note_played;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] r;
        // Reset held with all requests high.
        for (int i = 0; i < 3; i++) step(1'b1, 6'h3F);
        idle(2);
        // Single coin.
        step(1'b0, 6'b000001);
        idle(20);
        // Simultaneous requests: product 1 wins.
        step(1'b0, 6'b001101);
        idle(20);
        // Back-to-back: 500-won then product 2 during step 2.
        step(1'b0, 6'b000010);
        idle(5);
        step(1'b0, 6'b010000);
        idle(40);
        // Overwrite: bit0 in step 1, bit3 in step 3.
        step(1'b0, 6'b000001);
        idle(1);
        step(1'b0, 6'b000001);
        idle(6);
        step(1'b0, 6'b001000);
        idle(40);
        // Request on the exact end cycle beats the slot holding code 4.
        step(1'b0, 6'b000001);
        step(1'b0, 6'b001000);
        idle(14);
        step(1'b0, 6'b100000);
        idle(20);
        // Reset during step 3 with code 6 pending.
        step(1'b0, 6'b000001);
        step(1'b0, 6'b100000);
        idle(8);
        step(1'b1, 6'd0);
        idle(20);
        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            r = 6'd0;
            if ($urandom_range(0, 7) == 0) begin
                r = 6'($urandom_range(1, 63));
            end
            step($urandom_range(0, 63) == 0, r);
        end
        idle(40);
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
